// File: rtl/spi_sram_responder_os.sv
// Oversampled SPI mode-0 serial-SRAM responder (23LC1024-style commands) running on the system clock.
// SPI pins are synchronised and edge-detected; a byte-wide memory port with 1-cycle read latency is driven.
module spi_sram_responder_os #(
  parameter int          ADDR_BITS   = 24,
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  MODE_RESET  = 8'h40
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sclk,
  input  logic                 cs_n,
  input  logic                 mosi,
  output logic                 miso,
  output logic                 miso_oe,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_en,
  output logic                 mem_wr,
  output logic [7:0]           mem_wdata,
  input  logic [7:0]           mem_rdata
);

  localparam int ABYTES = ADDR_BITS / 8;
  localparam int ACW    = (ABYTES > 1) ? $clog2(ABYTES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DATA_RD, S_DATA_WR, S_MODE_RD, S_MODE_WR, S_IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_s, cs_s, mosi_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_s <= '0;
      cs_s   <= '1;
      mosi_s <= '0;
    end else begin
      sclk_s <= {sclk_s[SYNC_STAGES-2:0], sclk};
      cs_s   <= {cs_s[SYNC_STAGES-2:0], cs_n};
      mosi_s <= {mosi_s[SYNC_STAGES-2:0], mosi};
    end
  end

  // A deselect seen in either of the last two stages wins over an sclk edge in the same cycle.
  logic sclk_rise, sclk_fall, cs_high, mosi_bit;
  assign sclk_rise = sclk_s[SYNC_STAGES-2] & ~sclk_s[SYNC_STAGES-1];
  assign sclk_fall = ~sclk_s[SYNC_STAGES-2] & sclk_s[SYNC_STAGES-1];
  assign cs_high   = cs_s[SYNC_STAGES-2] | cs_s[SYNC_STAGES-1];
  assign mosi_bit  = mosi_s[SYNC_STAGES-1];

  state_t                state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [7:0]            shift_q, shift_d;
  logic [ACW-1:0]        abyte_q, abyte_d;
  logic                  is_rd_q, is_rd_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [7:0]            tx_q, tx_d;
  logic                  rd_pend_q, rd_pend_d;
  logic [7:0]            mode_q, mode_d;
  logic                  mode_set_q, mode_set_d;
  logic                  miso_d, oe_d, mem_en_d, mem_wr_d;
  logic [ADDR_BITS-1:0]  mem_addr_d, addr_next;
  logic [7:0]            mem_wdata_d, rx_byte;
  logic                  byte_done;

  assign rx_byte   = {shift_q[6:0], mosi_bit};
  assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);
  assign addr_next = ADDR_BITS'({addr_q, rx_byte});

  // NOTE: every next-state variable gets a default before any branch, so no latch can be inferred.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    abyte_d     = abyte_q;
    is_rd_d     = is_rd_q;
    addr_d      = addr_q;
    tx_d        = tx_q;
    mode_d      = mode_q;
    mode_set_d  = mode_set_q;
    miso_d      = miso;
    oe_d        = miso_oe;
    mem_en_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    // Read data is valid the cycle after the read strobe.
    rd_pend_d   = mem_en & ~mem_wr;

    if (rd_pend_q) tx_d = mem_rdata;

    if (cs_high) begin
      state_d   = S_IDLE;
      bit_cnt_d = '0;
      oe_d      = 1'b0;
    end else begin
      if (sclk_rise) begin
        shift_d   = rx_byte;
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      if (sclk_fall && miso_oe) begin
        miso_d = tx_q[7];
        tx_d   = {tx_q[6:0], 1'b0};
      end

      unique case (state_q)
        S_IDLE: state_d = S_CMD;
        S_CMD: if (byte_done) begin
          abyte_d = '0;
          case (rx_byte)
            8'h03:   begin is_rd_d = 1'b1; state_d = S_ADDR; end
            8'h02:   begin is_rd_d = 1'b0; state_d = S_ADDR; end
            8'h05:   begin tx_d = mode_q; oe_d = 1'b1; state_d = S_MODE_RD; end
            8'h01:   begin mode_set_d = 1'b0; state_d = S_MODE_WR; end
            default: state_d = S_IGNORE;
          endcase
        end
        S_ADDR: if (byte_done) begin
          addr_d  = addr_next;
          abyte_d = abyte_q + 1'b1;
          if (abyte_q == ACW'(ABYTES - 1)) begin
            if (is_rd_q) begin
              mem_en_d   = 1'b1;
              mem_addr_d = addr_next;
              oe_d       = 1'b1;
              state_d    = S_DATA_RD;
            end else begin
              state_d = S_DATA_WR;
            end
          end
        end
        S_DATA_RD: if (byte_done) begin
          // Prefetch the next byte so it is loaded before the following sclk fall.
          addr_d     = addr_q + 1'b1;
          mem_en_d   = 1'b1;
          mem_addr_d = addr_q + 1'b1;
        end
        S_DATA_WR: if (byte_done) begin
          mem_en_d    = 1'b1;
          mem_wr_d    = 1'b1;
          mem_wdata_d = rx_byte;
          mem_addr_d  = addr_q;
          addr_d      = addr_q + 1'b1;
        end
        S_MODE_RD: if (byte_done) tx_d = mode_q;
        S_MODE_WR: if (byte_done && !mode_set_q) begin
          mode_d     = rx_byte;
          mode_set_d = 1'b1;
        end
        S_IGNORE: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments only; the comb block above uses blocking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      abyte_q    <= '0;
      is_rd_q    <= 1'b0;
      addr_q     <= '0;
      tx_q       <= '0;
      rd_pend_q  <= 1'b0;
      mode_q     <= MODE_RESET;
      mode_set_q <= 1'b0;
      miso       <= 1'b0;
      miso_oe    <= 1'b0;
      mem_en     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      abyte_q    <= abyte_d;
      is_rd_q    <= is_rd_d;
      addr_q     <= addr_d;
      tx_q       <= tx_d;
      rd_pend_q  <= rd_pend_d;
      mode_q     <= mode_d;
      mode_set_q <= mode_set_d;
      miso       <= miso_d;
      miso_oe    <= oe_d;
      mem_en     <= mem_en_d;
      mem_wr     <= mem_wr_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_spi_sram_responder_os.sv
// Directed bench for spi_sram_responder_os: SPI master at sclk = clk/8 plus a 1-cycle-latency byte memory.
`timescale 1ns/1ps
module tb_spi_sram_responder_os;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso, miso_oe, mem_en, mem_wr;
  logic [23:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;

  always #5 clk = ~clk;

  spi_sram_responder_os dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .mem_addr  (mem_addr),
    .mem_en    (mem_en),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  logic [7:0] mem [logic [23:0]];

  always @(posedge clk) begin
    if (mem_en && mem_wr) mem[mem_addr] = mem_wdata;
    else if (mem_en) mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 8'h00;
  end

  int          en_cnt = 0;
  logic [31:0] wr_log [$];
  logic [23:0] rd_log [$];
  bit          oe_seen = 1'b0;

  always @(negedge clk) begin
    if (mem_en === 1'b1) begin
      en_cnt++;
      if (mem_wr) wr_log.push_back({mem_addr, mem_wdata});
      else        rd_log.push_back(mem_addr);
    end
    if (miso_oe === 1'b1) oe_seen = 1'b1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] wr_at(input int i);
    return (i < wr_log.size()) ? wr_log[i] : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [23:0] rd_at(input int i);
    return (i < rd_log.size()) ? rd_log[i] : 24'hFFFFFF;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode 0: mosi changes while sclk is low, miso is sampled just before each rise.
  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      wait_clk(4);
      rx = {rx[6:0], miso};
      sclk = 1'b1;
      wait_clk(4);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    spi_bits(tx, 8, rx);
  endtask

  task automatic cs_begin();
    cs_n = 1'b0;
    wait_clk(4);
  endtask

  task automatic cs_end();
    wait_clk(4);
    cs_n = 1'b1;
    mosi = 1'b0;
    wait_clk(8);
  endtask

  task automatic cmd_addr(input logic [7:0] cmd, input logic [23:0] addr);
    logic [7:0] dummy;
    spi_byte(cmd, dummy);
    spi_byte(addr[23:16], dummy);
    spi_byte(addr[15:8], dummy);
    spi_byte(addr[7:0], dummy);
  endtask

  task automatic clear_logs();
    en_cnt = 0;
    wr_log.delete();
    rd_log.delete();
    oe_seen = 1'b0;
  endtask

  task automatic read_mode(input string tag, input logic [7:0] exp);
    logic [7:0] rx;
    cs_begin();
    spi_byte(8'h05, rx);
    spi_byte(8'h00, rx);
    check(tag, {24'h0, rx}, {24'h0, exp});
    spi_byte(8'h00, rx);
    check({tag, "_repeat"}, {24'h0, rx}, {24'h0, exp});
    cs_end();
  endtask

  initial begin
    logic [7:0] rx;

    // 1: reset held while the SPI pins wiggle
    wait_clk(1);
    cs_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sclk = ~sclk;
      mosi = ~mosi;
      wait_clk(1);
    end
    check("rst_oe", {31'h0, miso_oe}, 32'h0);
    check("rst_en", {31'h0, mem_en}, 32'h0);
    sclk = 1'b0;
    mosi = 1'b0;
    cs_n = 1'b1;
    rst_n = 1'b1;
    wait_clk(4);
    check("rst_miso", {31'h0, miso}, 32'h0);
    check("rst_addr", {8'h0, mem_addr}, 32'h0);
    check("rst_en_cnt", en_cnt, 0);
    read_mode("rst_mode", 8'h40);

    // 2: sequential write
    clear_logs();
    cs_begin();
    cmd_addr(8'h02, 24'h000123);
    spi_byte(8'hDE, rx);
    spi_byte(8'hAD, rx);
    spi_byte(8'hBE, rx);
    cs_end();
    check("wr_en_cnt", en_cnt, 3);
    check("wr_0", wr_at(0), 32'h000123DE);
    check("wr_1", wr_at(1), 32'h000124AD);
    check("wr_2", wr_at(2), 32'h000125BE);

    // 3: sequential read with prefetch
    clear_logs();
    cs_begin();
    cmd_addr(8'h03, 24'h000123);
    spi_byte(8'h00, rx); check("rd_b0", {24'h0, rx}, 32'hDE);
    spi_byte(8'h00, rx); check("rd_b1", {24'h0, rx}, 32'hAD);
    spi_byte(8'h00, rx); check("rd_b2", {24'h0, rx}, 32'hBE);
    cs_end();
    check("rd_cnt", rd_log.size(), 4);
    check("rd_a0", {8'h0, rd_at(0)}, 32'h000123);
    check("rd_a1", {8'h0, rd_at(1)}, 32'h000124);
    check("rd_a2", {8'h0, rd_at(2)}, 32'h000125);
    check("rd_a3", {8'h0, rd_at(3)}, 32'h000126);
    check("rd_no_wr", wr_log.size(), 0);
    check("rd_oe_seen", {31'h0, oe_seen}, 32'h1);
    check("rd_oe_off", {31'h0, miso_oe}, 32'h0);

    // 4: address wrap in both directions
    clear_logs();
    cs_begin();
    cmd_addr(8'h02, 24'hFFFFFF);
    spi_byte(8'h11, rx);
    spi_byte(8'h22, rx);
    cs_end();
    check("wrap_wr_cnt", en_cnt, 2);
    check("wrap_wr_0", wr_at(0), 32'hFFFFFF11);
    check("wrap_wr_1", wr_at(1), 32'h00000022);
    clear_logs();
    cs_begin();
    cmd_addr(8'h03, 24'hFFFFFF);
    spi_byte(8'h00, rx); check("wrap_rd_0", {24'h0, rx}, 32'h11);
    spi_byte(8'h00, rx); check("wrap_rd_1", {24'h0, rx}, 32'h22);
    cs_end();
    check("wrap_rd_a1", {8'h0, rd_at(1)}, 32'h000000);

    // 5: deselect mid-byte discards the partial byte
    clear_logs();
    cs_begin();
    cmd_addr(8'h02, 24'h000010);
    spi_byte(8'hA5, rx);
    spi_bits(8'h3C, 4, rx);
    cs_end();
    check("abort_cnt", en_cnt, 1);
    check("abort_wr", wr_at(0), 32'h000010A5);
    check("abort_no_11", {31'h0, mem.exists(24'h000011)}, 32'h0);
    read_mode("abort_mode", 8'h40);

    // 6: mode write (only first byte counts), then unknown command
    cs_begin();
    spi_byte(8'h01, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h77, rx);
    cs_end();
    read_mode("mode_wr", 8'h00);
    clear_logs();
    cs_begin();
    spi_byte(8'h9F, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h00, rx);
    cs_end();
    check("ign_oe", {31'h0, oe_seen}, 32'h0);
    check("ign_en", en_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
